pipeline_stage_ctrl: RTL and testbench
======================================

Name: pipeline_stage_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB). It arbitrates three hazard sources and drives every inter-stage register enable and flush from one place:
- load-use dependency on the instruction in EX;
- taken-branch redirect from EX;
- multi-cycle data-memory access in MEM.
It also runs a post-reset pipeline purge sequence.

Parameters:
STARTUP_CYCLES, 4, cycles after reset release during which all stages are flushed and the PC is held (1..15).
LOAD_OPCODE, 7'b0000011, opcode treated as a load for hazard tracking.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_opcode  in  7  opcode of the instruction in ID
id_rd_addr  in  5  rd of the instruction in ID
id_rs1_addr  in  5  rs1 of the instruction in ID
id_rs2_addr  in  5  rs2 of the instruction in ID
ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle
mem_req  in  1  load/store present in MEM requesting dmem
dmem_ready  in  1  dmem completes the current access this cycle
pc_en  out  1  PC register update enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX register enable
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
stall  out  1  any stage held this cycle
stall_cycles  out  32  stall-cycle counter (optional feature)

Behaviour:
- FSM states: STARTUP, RUN, MEM_WAIT. Async reset -> STARTUP, cnt=0, ex_load_v=0, ex_rd=0.
- Outputs are combinational from state, tracking registers and inputs (zero-latency).
- Outputs during reset: pc_en=0, all *_en=1, both flushes=1, stall=1.

STARTUP:
- pc_en=0; all *_en=1; if_id_flush=id_ex_flush=1; stall=1.
- cnt increments each cycle; at cnt==STARTUP_CYCLES-1 -> RUN.

RUN, priority high to low:
1. mem_req && !dmem_ready:
   - All enables=0, no flush, stall=1; -> MEM_WAIT.
   - Checked first, so branch and load-use are ignored this cycle.
2. ex_branch_taken:
   - All enables=1; if_id_flush=id_ex_flush=1; stall=0.
   - A coincident load-use is squashed.
3. Load-use (ex_load_v && ex_rd!=0 && (ex_rd==id_rs1_addr || ex_rd==id_rs2_addr)):
   - pc_en=if_id_en=0; id_ex_en=ex_mem_en=mem_wb_en=1; id_ex_flush=1; stall=1.
   - Exactly one bubble per hazard.
4. Otherwise: all enables=1, flushes=0, stall=0.

MEM_WAIT:
- All enables=0, stall=1, until dmem_ready=1.
- On the dmem_ready cycle: evaluate the RUN rules with mem_req treated as satisfied (rules 2-4 apply), then -> RUN.

EX tracking registers (update only on cycles where id_ex_en=1):
- id_ex_flush=1: ex_load_v<=0.
- Otherwise: ex_load_v<=(id_opcode==LOAD_OPCODE); ex_rd<=id_rd_addr.
- When id_ex_en=0 they hold.

Boundary cases:
- x0 as destination never stalls.
- Load followed by a load that uses it: one bubble only.
- Reset asserted mid-MEM_WAIT returns immediately to STARTUP.

Optional Feature:
STALL_COUNTER_EN:
- Defined: stall_cycles is a 32-bit counter, +1 on every cycle with stall=1 in state RUN or MEM_WAIT, saturating at 32'hFFFFFFFF; reset to 0.
- Undefined: stall_cycles is tied to 32'h0 and no counter flops exist.

Decomposition:
- Shared package pipe_ctrl_pkg holds: FSM state encoding (STARTUP=2'd0, RUN=2'd1, MEM_WAIT=2'd2), the opcode constants (LOAD, STORE, BRANCH, JAL, JALR) and the register-address width (5).
- One natural sub-module: hazard_detect_unit.
  - Holds the combinational load-use compare plus the ex_load_v/ex_rd tracking registers.
  - Outputs load_use.

Test Plan:
1. Reset release with STARTUP_CYCLES=4 -> pc_en=0, both flushes=1 for exactly 4 cycles, then pc_en=1, stall=0.
2. lw x5 then add x6,x5,x1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1, stall=1; next cycle all enables=1. Same sequence with rd=x0 -> no stall.
3. mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all enables=0 for 3 cycles, state MEM_WAIT; on the ready cycle enables=1, state RUN.
4. ex_branch_taken=1 in the same cycle as a load-use match -> if_id_flush=id_ex_flush=1, pc_en=1, stall=0; no bubble on the following cycle.
5. ex_branch_taken=1 while mem_req=1, dmem_ready=0 -> freeze (all enables=0) until ready; branch flush applied on the ready cycle.
6. STALL_COUNTER_EN defined: 2 load-use stalls plus 3 MEM_WAIT cycles -> stall_cycles=5; macro undefined -> stall_cycles=0.

Source files
------------

// File: rtl/pipeline_stage_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Optional feature macro: STALL_COUNTER_EN (see pipeline_stage_ctrl.sv).
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        ST_STARTUP  = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_stage_ctrl_if.sv
// Hazard inputs and stage enable/flush outputs of the sequencer.
// master = pipeline datapath, slave = the stall/flush controller.
interface pipeline_stage_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [6:0]  id_opcode;
    reg_addr_t   id_rd_addr;
    reg_addr_t   id_rs1_addr;
    reg_addr_t   id_rs2_addr;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        dmem_ready;

    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        stall;
    logic [31:0] stall_cycles;

    modport master (
        output id_opcode, id_rd_addr, id_rs1_addr, id_rs2_addr,
        output ex_branch_taken, mem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, stall, stall_cycles
    );

    modport slave (
        input  id_opcode, id_rd_addr, id_rs1_addr, id_rs2_addr,
        input  ex_branch_taken, mem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, stall, stall_cycles
    );

endinterface

// File: rtl/pipeline_stage_ctrl_hazard_detect_unit.sv
// Load-use detector: remembers whether EX holds a load and its rd,
// and flags an ID instruction that reads that rd.
module hazard_detect_unit
    import pipe_ctrl_pkg::*;
#(
    parameter logic [6:0] LOAD_OPCODE = OPC_LOAD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] i_id_opcode,
    input  reg_addr_t  i_id_rd_addr,
    input  reg_addr_t  i_id_rs1_addr,
    input  reg_addr_t  i_id_rs2_addr,
    input  logic       i_id_ex_en,
    input  logic       i_id_ex_flush,
    output logic       o_load_use
);

    logic      r_ex_load_v;
    reg_addr_t r_ex_rd;

    // Shadow the ID/EX register: follow it when enabled, clear on bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_load_v <= 1'b0;
            r_ex_rd     <= '0;
        end else if (i_id_ex_en) begin
            if (i_id_ex_flush) begin
                r_ex_load_v <= 1'b0;
            end else begin
                r_ex_load_v <= (i_id_opcode == LOAD_OPCODE);
                r_ex_rd     <= i_id_rd_addr;
            end
        end
    end

    // x0 is never a real producer, so it cannot create a hazard.
    assign o_load_use = r_ex_load_v
                     && (r_ex_rd != '0)
                     && ((r_ex_rd == i_id_rs1_addr)
                      || (r_ex_rd == i_id_rs2_addr));

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// Central stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline.
// Define STALL_COUNTER_EN to build the saturating stall-cycle counter.
module pipeline_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int         STARTUP_CYCLES = 4,
    parameter logic [6:0] LOAD_OPCODE    = OPC_LOAD
) (
    input  logic clk,
    input  logic rst_n,
    pipeline_stage_ctrl_if.slave bus
);

    localparam logic [3:0] LP_START_LAST = 4'(STARTUP_CYCLES - 1);

    ctrl_state_e r_state;
    logic [3:0]  r_cnt;

    logic w_load_use;
    logic w_startup;
    logic w_freeze;
    logic w_redirect;
    logic w_bubble;

    logic w_pc_en;
    logic w_if_id_en;
    logic w_id_ex_en;
    logic w_ex_mem_en;
    logic w_mem_wb_en;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_stall;

    hazard_detect_unit #(
        .LOAD_OPCODE (LOAD_OPCODE)
    ) u_hazard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_id_opcode   (bus.id_opcode),
        .i_id_rd_addr  (bus.id_rd_addr),
        .i_id_rs1_addr (bus.id_rs1_addr),
        .i_id_rs2_addr (bus.id_rs2_addr),
        .i_id_ex_en    (w_id_ex_en),
        .i_id_ex_flush (w_id_ex_flush),
        .o_load_use    (w_load_use)
    );

    // Mutually exclusive cycle classes, highest priority first.
    // A pending dmem access (RUN) or wait (MEM_WAIT) freezes everything;
    // on the ready cycle of MEM_WAIT the normal rules apply again.
    always_comb begin
        w_startup  = (r_state == ST_STARTUP);
        w_freeze   = ((r_state == ST_RUN)
                      && bus.mem_req && !bus.dmem_ready)
                  || ((r_state == ST_MEM_WAIT) && !bus.dmem_ready);
        w_redirect = !w_startup && !w_freeze && bus.ex_branch_taken;
        w_bubble   = !w_startup && !w_freeze && !bus.ex_branch_taken
                  && w_load_use;
    end

    // Stage enables and flushes, decoded directly from the cycle class.
    always_comb begin
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_id_ex_en    = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_mem_wb_en   = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_stall       = 1'b0;
        unique case (1'b1)
            w_startup: begin
                w_pc_en       = 1'b0;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                w_stall       = 1'b1;
            end
            w_freeze: begin
                w_pc_en     = 1'b0;
                w_if_id_en  = 1'b0;
                w_id_ex_en  = 1'b0;
                w_ex_mem_en = 1'b0;
                w_mem_wb_en = 1'b0;
                w_stall     = 1'b1;
            end
            w_redirect: begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end
            w_bubble: begin
                w_pc_en       = 1'b0;
                w_if_id_en    = 1'b0;
                w_id_ex_flush = 1'b1;
                w_stall       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Sequencer: purge after reset, then run / wait on dmem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STARTUP;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_STARTUP: begin
                    if (r_cnt == LP_START_LAST) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (bus.mem_req && !bus.dmem_ready) begin
                        r_state <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_STARTUP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef STALL_COUNTER_EN
    logic [31:0] r_stall_cycles;

    // Count stalled cycles after the purge, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && !w_startup
                     && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = '0;
`endif

    assign bus.pc_en       = w_pc_en;
    assign bus.if_id_en    = w_if_id_en;
    assign bus.id_ex_en    = w_id_ex_en;
    assign bus.ex_mem_en   = w_ex_mem_en;
    assign bus.mem_wb_en   = w_mem_wb_en;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.id_ex_flush = w_id_ex_flush;
    assign bus.stall       = w_stall;

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Directed-vector bench for pipeline_stage_ctrl.
// Build with +define+STALL_COUNTER_EN to also check the stall counter.
module tb_pipeline_stage_ctrl;
    import pipe_ctrl_pkg::*;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    //  if_id_flush, id_ex_flush, stall}
    localparam logic [7:0] V_START = 8'b0111_1111;
    localparam logic [7:0] V_RUN   = 8'b1111_1000;
    localparam logic [7:0] V_FRZ   = 8'b0000_0001;
    localparam logic [7:0] V_REDIR = 8'b1111_1110;
    localparam logic [7:0] V_BUB   = 8'b0011_1011;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] ALU = 7'b0110011;
    localparam logic [6:0] NOP = 7'b0010011;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipeline_stage_ctrl_if bus();

    pipeline_stage_ctrl #(
        .STARTUP_CYCLES (4),
        .LOAD_OPCODE    (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int exp_stalls = 0;
    bit cnt_en     = 1'b0;

    logic [7:0] w_out;
    assign w_out = {bus.pc_en, bus.if_id_en, bus.id_ex_en,
                    bus.ex_mem_en, bus.mem_wb_en,
                    bus.if_id_flush, bus.id_ex_flush, bus.stall};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string      tag,
                        input logic [6:0] opc,
                        input logic [4:0] rd,
                        input logic [4:0] rs1,
                        input logic [4:0] rs2,
                        input logic       br,
                        input logic       mreq,
                        input logic       rdy,
                        input logic [7:0] exp);
        @(negedge clk);
        bus.id_opcode       = opc;
        bus.id_rd_addr      = rd;
        bus.id_rs1_addr     = rs1;
        bus.id_rs2_addr     = rs2;
        bus.ex_branch_taken = br;
        bus.mem_req         = mreq;
        bus.dmem_ready      = rdy;
        #1;
        chk(tag, {24'b0, w_out}, {24'b0, exp});
        if (cnt_en && exp[0]) exp_stalls++;
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.id_opcode       = NOP;
        bus.id_rd_addr      = '0;
        bus.id_rs1_addr     = '0;
        bus.id_rs2_addr     = '0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_req         = 1'b0;
        bus.dmem_ready      = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_out", {24'b0, w_out}, {24'b0, V_START});
        chk("rst_cnt", bus.stall_cycles, 32'd0);

        // Purge: four cycles of flush with PC held.
        rst_n = 1'b1;
        #1;
        chk("start0", {24'b0, w_out}, {24'b0, V_START});
        step("start1", NOP, 0, 0, 0, 0, 0, 0, V_START);
        step("start2", NOP, 0, 0, 0, 0, 0, 0, V_START);
        step("start3", NOP, 0, 0, 0, 0, 0, 0, V_START);
        step("run0",   NOP, 0, 0, 0, 0, 0, 0, V_RUN);
        cnt_en = 1'b1;

        // Load-use on rs1, then released after one bubble.
        step("lw_x5",      LW,  5, 1, 0, 0, 0, 0, V_RUN);
        step("lu_bubble",  ALU, 6, 5, 1, 0, 0, 0, V_BUB);
        step("lu_release", ALU, 6, 5, 1, 0, 0, 0, V_RUN);
        // Load into x0 never stalls.
        step("lw_x0",      LW,  0, 1, 0, 0, 0, 0, V_RUN);
        step("x0_nostall", ALU, 6, 0, 1, 0, 0, 0, V_RUN);
        // Load-use on rs2.
        step("lw_x7",      LW,  7, 2, 0, 0, 0, 0, V_RUN);
        step("lu_rs2",     ALU, 8, 1, 7, 0, 0, 0, V_BUB);
        step("lu_rs2_rel", ALU, 8, 1, 7, 0, 0, 0, V_RUN);
        // ALU producer never stalls.
        step("alu_x3",     ALU, 3, 1, 2, 0, 0, 0, V_RUN);
        step("alu_dep",    ALU, 4, 3, 3, 0, 0, 0, V_RUN);
        // Load feeding a load: one bubble, then the second load's hazard.
        step("ll_1",       LW,  5, 1, 0, 0, 0, 0, V_RUN);
        step("ll_2",       LW,  9, 5, 0, 0, 0, 0, V_BUB);
        step("ll_2_rel",   LW,  9, 5, 0, 0, 0, 0, V_RUN);
        step("ll_use",     ALU, 10, 9, 0, 0, 0, 0, V_BUB);
        step("ll_use_rel", ALU, 10, 9, 0, 0, 0, 0, V_RUN);

        // Multi-cycle dmem: 3 frozen cycles, release on ready.
        step("mw_enter",   NOP, 0, 0, 0, 0, 1, 0, V_FRZ);
        step("mw_hold",    NOP, 0, 0, 0, 0, 0, 0, V_FRZ);
        step("mw_hold2",   NOP, 0, 0, 0, 0, 1, 0, V_FRZ);
        step("mw_ready",   NOP, 0, 0, 0, 0, 1, 1, V_RUN);
        step("mw_back",    NOP, 0, 0, 0, 0, 0, 0, V_RUN);
        step("run_req_rdy", NOP, 0, 0, 0, 0, 1, 1, V_RUN);

        // Branch squashes a coincident load-use.
        step("br_lw",      LW,  5, 1, 0, 0, 0, 0, V_RUN);
        step("br_squash",  ALU, 6, 5, 1, 1, 0, 0, V_REDIR);
        step("br_nobub",   ALU, 6, 5, 1, 0, 0, 0, V_RUN);

        // Branch under a dmem wait: freeze, then flush on ready.
        step("bm_lw",      LW,  5, 1, 0, 0, 0, 0, V_RUN);
        step("bm_frz",     ALU, 6, 5, 1, 1, 1, 0, V_FRZ);
        step("bm_wait",    ALU, 6, 5, 1, 1, 1, 0, V_FRZ);
        step("bm_ready",   ALU, 6, 5, 1, 1, 1, 1, V_REDIR);
        step("bm_after",   ALU, 6, 5, 1, 0, 0, 0, V_RUN);

        // Load tracking survives a freeze; bubble on the ready cycle.
        step("ml_lw",      LW,  5, 1, 0, 0, 0, 0, V_RUN);
        step("ml_frz",     ALU, 6, 5, 1, 0, 1, 0, V_FRZ);
        step("ml_ready",   ALU, 6, 5, 1, 0, 1, 1, V_BUB);
        step("ml_after",   ALU, 6, 5, 1, 0, 0, 0, V_RUN);

        step("idle",       NOP, 0, 0, 0, 0, 0, 0, V_RUN);
`ifdef STALL_COUNTER_EN
        chk("stall_cycles", bus.stall_cycles, 32'(exp_stalls));
`else
        chk("stall_cycles", bus.stall_cycles, 32'd0);
`endif

        // Reset in the middle of a dmem wait.
        step("rw_enter",   NOP, 0, 0, 0, 0, 1, 0, V_FRZ);
        step("rw_wait",    NOP, 0, 0, 0, 0, 1, 0, V_FRZ);
        cnt_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_midwait", {24'b0, w_out}, {24'b0, V_START});
        chk("rst_cnt_clr", bus.stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_req = 1'b0;
        #1;
        chk("restart0", {24'b0, w_out}, {24'b0, V_START});
        step("restart1", NOP, 0, 0, 0, 0, 0, 0, V_START);
        step("restart2", NOP, 0, 0, 0, 0, 0, 0, V_START);
        step("restart3", NOP, 0, 0, 0, 0, 0, 0, V_START);
        step("rerun",    NOP, 0, 0, 0, 0, 0, 0, V_RUN);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
